// File: rtl/apb_mem_window_pkg.sv
// Shared types, response codes and entry-geometry helpers for the APB memory window bridge.
package apb_mem_window_pkg;

   typedef logic [31:0] apbAddrT;
   typedef logic [31:0] apbDataT;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WR_COMMIT = 2'd1,
      RD_WAIT   = 2'd2,
      RD_RESP   = 2'd3
   } bridgeStateT;

   localparam apbDataT BADD_CODE    = 32'hBADD_C0DE;
   localparam apbDataT TIMEOUT_CODE = 32'hDEAD_0001;

   function automatic int wpe_f(input int entry_w);
      return (entry_w + 31) / 32;
   endfunction

   function automatic int wlog_f(input int entry_w);
      return $clog2(wpe_f(entry_w));
   endfunction

   // Byte distance between consecutive entries: word slots rounded up to a power of two.
   function automatic int stride_f(input int entry_w);
      return 4 << wlog_f(entry_w);
   endfunction

endpackage

// File: rtl/apb_mem_window_decode.sv
// Combinational APB address decode: paddr -> hit, table one-hot, entry index and word select.
module apb_mem_window_decode
   import apb_mem_window_pkg::*;
#(
   parameter int NUM_TABLES = 2,
   parameter int ENTRY_W = 64,
   parameter int IDX_W = 8,
   parameter logic [NUM_TABLES*32-1:0] TBL_BASE = {32'h100, 32'h0},
   parameter logic [NUM_TABLES*16-1:0] TBL_DEPTH = {16'd8, 16'd10},
   localparam int WPE = wpe_f(ENTRY_W),
   localparam int WLOG = wlog_f(ENTRY_W),
   localparam int WORD_W = (WLOG > 0) ? WLOG : 1
)(
   input  apbAddrT                 paddr,
   output logic                    hit,
   output logic [NUM_TABLES-1:0]   tbl,
   output logic [IDX_W-1:0]        idx,
   output logic [WORD_W-1:0]       word
);

   localparam int STRIDE = stride_f(ENTRY_W);
   localparam int SHIFT = 2 + WLOG;

   logic [NUM_TABLES-1:0] in_range;
   logic [IDX_W-1:0]      idx_t [NUM_TABLES];
   logic                  word_ok;

   for (genvar t = 0; t < NUM_TABLES; t++) begin : g_tbl
      localparam apbAddrT BASE = TBL_BASE[t*32 +: 32];
      localparam apbAddrT SPAN = apbAddrT'(TBL_DEPTH[t*16 +: 16]) * apbAddrT'(STRIDE);
      apbAddrT off;
      assign off         = paddr - BASE;
      assign in_range[t] = (paddr >= BASE) && (off < SPAN);
      assign idx_t[t]    = IDX_W'(off >> SHIFT);
   end

   if (WLOG > 0) begin : g_word
      assign word = paddr[SHIFT-1:2];
   end else begin : g_word1
      assign word = 1'b0;
   end

   assign word_ok = (int'(word) < WPE);

   // Tables are span-aligned and disjoint, so at most one index contributes.
   always_comb begin
      idx = '0;
      for (int t = 0; t < NUM_TABLES; t++)
         if (in_range[t]) idx |= idx_t[t];
   end

   assign tbl = word_ok ? in_range : '0;
   assign hit = |tbl;

endmodule

// File: rtl/apb_mem_window_bridge.sv
// APB slave mapping NUM_TABLES memory tables into one window with staged writes and snapshot reads.
// Optional read-wait timeout is compiled in with `define APBMEM_TIMEOUT_EN.
module apb_mem_window_bridge
   import apb_mem_window_pkg::*;
#(
   parameter int NUM_TABLES = 2,
   parameter int ENTRY_W = 64,
   parameter int IDX_W = 8,
   parameter logic [NUM_TABLES*32-1:0] TBL_BASE = {32'h100, 32'h0},
   parameter logic [NUM_TABLES*16-1:0] TBL_DEPTH = {16'd8, 16'd10},
   parameter int TIMEOUT = 64
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           psel,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [31:0]                    paddr,
   input  logic [31:0]                    pwdata,
   output logic [31:0]                    prdata,
   output logic                           pready,
   output logic                           pslverr,
   output logic [NUM_TABLES-1:0]          mem_en,
   output logic                           mem_wr_en,
   output logic [IDX_W-1:0]               mem_addr,
   output logic [ENTRY_W-1:0]             mem_wdata,
   input  logic [NUM_TABLES*ENTRY_W-1:0]  mem_rdata,
   input  logic [NUM_TABLES-1:0]          mem_rvalid
);

   localparam int WPE = wpe_f(ENTRY_W);
   localparam int WLOG = wlog_f(ENTRY_W);
   localparam int WORD_W = (WLOG > 0) ? WLOG : 1;
   localparam int VEC_W = WPE * 32;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WPE - 1);

   bridgeStateT state, state_nxt;

   logic                  hit;
   logic [NUM_TABLES-1:0] tbl, tbl_q;
   logic [IDX_W-1:0]      idx;
   logic [WORD_W-1:0]     word;

   apbDataT               stage [WPE];
   logic [VEC_W-1:0]      snapshot, commit_vec, rdata_ext;
   logic [ENTRY_W-1:0]    rdata_sel;
   apbDataT               snap_word;
   logic                  access, rvalid_sel, timed_out, dropped, rd_err;

   apb_mem_window_decode #(
      .NUM_TABLES (NUM_TABLES),
      .ENTRY_W    (ENTRY_W),
      .IDX_W      (IDX_W),
      .TBL_BASE   (TBL_BASE),
      .TBL_DEPTH  (TBL_DEPTH)
   ) u_decode (
      .paddr (paddr),
      .hit   (hit),
      .tbl   (tbl),
      .idx   (idx),
      .word  (word)
   );

   assign access     = rst_n && psel && penable;
   assign rvalid_sel = |(mem_rvalid & tbl_q);
   assign snap_word  = apbDataT'(snapshot >> (32 * word));
   assign rdata_ext  = VEC_W'(rdata_sel);

   // Top staged word comes live from pwdata; the rest from the staging registers.
   always_comb begin
      commit_vec = '0;
      rdata_sel  = '0;
      for (int w = 0; w < WPE; w++)
         commit_vec[w*32 +: 32] = (w == WPE - 1) ? pwdata : stage[w];
      for (int t = 0; t < NUM_TABLES; t++)
         if (tbl_q[t]) rdata_sel = mem_rdata[t*ENTRY_W +: ENTRY_W];
   end

`ifdef APBMEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               wait_cnt <= '0;
      else if (state != RD_WAIT) wait_cnt <= '0;
      else                      wait_cnt <= wait_cnt + CNT_W'(1);
   end

   assign timed_out = (state == RD_WAIT) && !rvalid_sel && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      pready    = 1'b0;
      pslverr   = 1'b0;
      prdata    = '0;
      case (state)
         IDLE: begin
            if (access) begin
               if (!hit) begin
                  pready  = 1'b1;
                  pslverr = 1'b1;
                  prdata  = pwrite ? '0 : BADD_CODE;
               end else if (pwrite) begin
                  if (word == LAST_WORD) state_nxt = WR_COMMIT;
                  else                   pready = 1'b1;
               end else if (word == '0) begin
                  state_nxt = RD_WAIT;
               end else begin
                  pready = 1'b1;
                  prdata = snap_word;
               end
            end
         end
         WR_COMMIT: begin
            pready    = psel && penable;
            state_nxt = IDLE;
         end
         RD_WAIT: begin
            if (rvalid_sel || timed_out) state_nxt = RD_RESP;
         end
         RD_RESP: begin
            state_nxt = IDLE;
            if (psel && penable && !dropped) begin
               pready  = 1'b1;
               pslverr = rd_err;
               prdata  = rd_err ? TIMEOUT_CODE : snapshot[31:0];
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tbl_q     <= '0;
         dropped   <= 1'b0;
         rd_err    <= 1'b0;
         snapshot  <= '0;
         mem_en    <= '0;
         mem_wr_en <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         for (int w = 0; w < WPE; w++) stage[w] <= '0;
      end else begin
         state     <= state_nxt;
         mem_en    <= '0;
         mem_wr_en <= 1'b0;
         if (state == IDLE && access && hit) begin
            if (pwrite && word != LAST_WORD) begin
               stage[word] <= pwdata;
            end else if (pwrite) begin
               mem_en    <= tbl;
               mem_wr_en <= 1'b1;
               mem_addr  <= idx;
               mem_wdata <= ENTRY_W'(commit_vec);
               tbl_q     <= tbl;
            end else if (word == '0) begin
               mem_en  <= tbl;
               mem_addr <= idx;
               tbl_q   <= tbl;
               dropped <= 1'b0;
               rd_err  <= 1'b0;
            end
         end
         // A master that abandons the wait still lets the memory read finish.
         if (state == RD_WAIT) begin
            if (!psel) dropped <= 1'b1;
            if (rvalid_sel)     snapshot <= rdata_ext;
            else if (timed_out) rd_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_mem_window_bridge.sv
// Directed bench for apb_mem_window_bridge: default 2x64-bit instance plus a 5-bit (single word) instance.
module tb_apb_mem_window_bridge;

   logic         clk, rst_n, psel, penable, pwrite, use5;
   logic [31:0]  paddr, pwdata;
   logic [31:0]  prdata0, prdata5;
   logic         pready0, pready5, pslverr0, pslverr5;
   logic [1:0]   en0, en5;
   logic         wr0, wr5;
   logic [7:0]   addr0, addr5;
   logic [63:0]  wdata0;
   logic [4:0]   wdata5;
   logic [127:0] mem_rdata;
   logic [9:0]   mem_rdata5;
   logic [1:0]   mem_rvalid;

   logic [31:0]  prdata_m;
   logic         pready_m, pslverr_m, wr_m;
   logic [1:0]   en_m;
   logic [7:0]   addr_m;
   logic [63:0]  wdata_m;

   int ntests = 0;
   int nfail = 0;
   int cyc = 0;
   int en_cnt = 0;
   int en_cyc = 0;
   logic [1:0]  last_en = '0;
   logic        last_wr = 1'b0;
   logic [7:0]  last_addr = '0;
   logic [63:0] last_wdata = '0;

   apb_mem_window_bridge #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .psel(psel && !use5), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
      .mem_en(en0), .mem_wr_en(wr0), .mem_addr(addr0), .mem_wdata(wdata0),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   apb_mem_window_bridge #(.ENTRY_W(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .psel(psel && use5), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata5), .pready(pready5), .pslverr(pslverr5),
      .mem_en(en5), .mem_wr_en(wr5), .mem_addr(addr5), .mem_wdata(wdata5),
      .mem_rdata(mem_rdata5), .mem_rvalid(mem_rvalid)
   );

   assign prdata_m  = use5 ? prdata5 : prdata0;
   assign pready_m  = use5 ? pready5 : pready0;
   assign pslverr_m = use5 ? pslverr5 : pslverr0;
   assign en_m      = use5 ? en5 : en0;
   assign wr_m      = use5 ? wr5 : wr0;
   assign addr_m    = use5 ? addr5 : addr0;
   assign wdata_m   = use5 ? {59'd0, wdata5} : wdata0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (en_m != 2'b00) begin
         en_cnt     = en_cnt + 1;
         en_cyc     = cyc;
         last_en    = en_m;
         last_wr    = wr_m;
         last_addr  = addr_m;
         last_wdata = wdata_m;
      end
   end

   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int waits, output int rcyc);
      waits = 0; rd = '0; er = 1'b0; rcyc = -1;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (pready_m) begin
            rd = prdata_m; er = pslverr_m; rcyc = cyc;
            break;
         end
         waits++;
      end
      if (rcyc < 0) begin
         ntests++; nfail++;
         $display("FAIL xfer_timeout: addr %h got no pready within 300 cycles, want pready", a);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic respond(input int t, input int dly, input logic [63:0] data, output int rvc);
      bit found = 0;
      rvc = -1;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (en_m[t]) found = 1;
      end
      if (found) begin
         repeat (dly) @(posedge clk);
         #1;
         mem_rdata[t*64 +: 64] = data;
         mem_rdata5[t*5 +: 5]  = data[4:0];
         mem_rvalid[t]         = 1'b1;
         rvc = cyc;
         @(posedge clk); #1;
         mem_rvalid = '0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ntests++; if ({pready0, pslverr0, prdata0} !== 34'd0) begin nfail++; $display("FAIL reset_apb: got %h want 0", {pready0, pslverr0, prdata0}); end
      ntests++; if ({en0, wr0, addr0, wdata0} !== 75'd0) begin nfail++; $display("FAIL reset_mem: got %h want 0", {en0, wr0, addr0, wdata0}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_wide_write();
      logic [31:0] rd; logic er; int w, rc, n0;
      n0 = en_cnt;
      xfer(1'b1, 32'h100, 32'hAAAA_5555, rd, er, w, rc);
      ntests++; if (w != 0) begin nfail++; $display("FAIL stage_waits: got %0d want 0", w); end
      ntests++; if (er !== 1'b0) begin nfail++; $display("FAIL stage_err: got %b want 0", er); end
      ntests++; if (en_cnt != n0) begin nfail++; $display("FAIL stage_no_mem: got %0d strobes want 0", en_cnt - n0); end
      n0 = en_cnt;
      xfer(1'b1, 32'h104, 32'h1234_5678, rd, er, w, rc);
      ntests++; if (w != 1) begin nfail++; $display("FAIL commit_waits: got %0d want 1", w); end
      ntests++; if (en_cnt - n0 != 1) begin nfail++; $display("FAIL commit_count: got %0d want 1", en_cnt - n0); end
      ntests++; if ({last_en, last_wr} !== 3'b101) begin nfail++; $display("FAIL commit_en: got %b want 101", {last_en, last_wr}); end
      ntests++; if (last_addr !== 8'd0) begin nfail++; $display("FAIL commit_addr: got %h want 00", last_addr); end
      ntests++; if (last_wdata !== 64'h1234_5678_AAAA_5555) begin nfail++; $display("FAIL commit_wdata: got %h want 12345678aaaa5555", last_wdata); end
      xfer(1'b1, 32'h104, 32'h9999_0000, rd, er, w, rc);
      ntests++; if (last_wdata !== 64'h9999_0000_AAAA_5555) begin nfail++; $display("FAIL recommit_wdata: got %h want 99990000aaaa5555", last_wdata); end
   endtask

   task automatic test_read_snapshot();
      logic [31:0] rd; logic er; int w, rc, rv, n0;
      n0 = en_cnt;
      fork
         xfer(1'b0, 32'h108, 32'h0, rd, er, w, rc);
         respond(1, 5, 64'hCAFE_F00D_0123_4567, rv);
      join
      ntests++; if (rd !== 32'h0123_4567) begin nfail++; $display("FAIL rd_low: got %h want 01234567", rd); end
      ntests++; if (er !== 1'b0) begin nfail++; $display("FAIL rd_err: got %b want 0", er); end
      ntests++; if (rc - rv != 1) begin nfail++; $display("FAIL rd_latency: got %0d cycles after rvalid want 1", rc - rv); end
      ntests++; if (en_cnt - n0 != 1) begin nfail++; $display("FAIL rd_count: got %0d want 1", en_cnt - n0); end
      ntests++; if ({last_en, last_wr, last_addr} !== {2'b10, 1'b0, 8'd1}) begin nfail++; $display("FAIL rd_strobe: got %h want %h", {last_en, last_wr, last_addr}, {2'b10, 1'b0, 8'd1}); end
      n0 = en_cnt;
      xfer(1'b0, 32'h10C, 32'h0, rd, er, w, rc);
      ntests++; if (rd !== 32'hCAFE_F00D) begin nfail++; $display("FAIL rd_high: got %h want cafef00d", rd); end
      ntests++; if (w != 0 || en_cnt != n0) begin nfail++; $display("FAIL rd_high_direct: got waits %0d strobes %0d want 0 0", w, en_cnt - n0); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int w, rc, n0;
      n0 = en_cnt;
      xfer(1'b0, 32'h150, 32'h0, rd, er, w, rc);
      ntests++; if ({er, rd} !== {1'b1, 32'hBADD_C0DE}) begin nfail++; $display("FAIL err_depth: got %b %h want 1 baddc0de", er, rd); end
      xfer(1'b0, 32'h200, 32'h0, rd, er, w, rc);
      ntests++; if ({er, rd} !== {1'b1, 32'hBADD_C0DE}) begin nfail++; $display("FAIL err_unmapped: got %b %h want 1 baddc0de", er, rd); end
      xfer(1'b1, 32'h154, 32'h5555_0000, rd, er, w, rc);
      ntests++; if (er !== 1'b1 || w != 0) begin nfail++; $display("FAIL err_write: got err %b waits %0d want 1 0", er, w); end
      ntests++; if (en_cnt != n0) begin nfail++; $display("FAIL err_no_mem: got %0d strobes want 0", en_cnt - n0); end
      xfer(1'b1, 32'h48, 32'h0000_1111, rd, er, w, rc);
      ntests++; if (er !== 1'b0 || w != 0) begin nfail++; $display("FAIL t0_stage: got err %b waits %0d want 0 0", er, w); end
      xfer(1'b1, 32'h4C, 32'h0000_2222, rd, er, w, rc);
      ntests++; if ({last_en, last_addr} !== {2'b01, 8'd9}) begin nfail++; $display("FAIL t0_commit: got %h want %h", {last_en, last_addr}, {2'b01, 8'd9}); end
      ntests++; if (last_wdata !== 64'h0000_2222_0000_1111) begin nfail++; $display("FAIL t0_wdata: got %h want 0000222200001111", last_wdata); end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] rd; logic er; int w, rc, rv;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      ntests++; if (addr0 !== 8'd2) begin nfail++; $display("FAIL mid_addr: got %h want 02", addr0); end
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      ntests++; if ({pready0, pslverr0, prdata0, en0, wr0} !== 37'd0) begin nfail++; $display("FAIL mid_reset_ctl: got %h want 0", {pready0, pslverr0, prdata0, en0, wr0}); end
      ntests++; if ({addr0, wdata0} !== 72'd0) begin nfail++; $display("FAIL mid_reset_mem: got %h want 0", {addr0, wdata0}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      fork
         xfer(1'b0, 32'h10, 32'h0, rd, er, w, rc);
         respond(0, 2, 64'h0000_0000_7777_8888, rv);
      join
      ntests++; if ({er, rd} !== {1'b0, 32'h7777_8888}) begin nfail++; $display("FAIL post_reset_rd: got %b %h want 0 77778888", er, rd); end
   endtask

   task automatic test_wpe1();
      logic [31:0] rd; logic er; int w, rc, rv, n0;
      use5 = 1'b1;
      n0 = en_cnt;
      xfer(1'b1, 32'h0, 32'h0000_00FF, rd, er, w, rc);
      ntests++; if (w != 1 || er !== 1'b0) begin nfail++; $display("FAIL w5_commit: got waits %0d err %b want 1 0", w, er); end
      ntests++; if (en_cnt - n0 != 1) begin nfail++; $display("FAIL w5_count: got %0d want 1", en_cnt - n0); end
      ntests++; if ({last_en, last_wr, last_wdata} !== {2'b01, 1'b1, 64'h1F}) begin nfail++; $display("FAIL w5_wdata: got %b %b %h want 01 1 1f", last_en, last_wr, last_wdata); end
      fork
         xfer(1'b0, 32'h0, 32'h0, rd, er, w, rc);
         respond(0, 1, 64'h1F, rv);
      join
      ntests++; if ({er, rd} !== {1'b0, 32'h1F}) begin nfail++; $display("FAIL w5_read: got %b %h want 0 0000001f", er, rd); end
      use5 = 1'b0;
   endtask

`ifdef APBMEM_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] rd; logic er; int w, rc;
      xfer(1'b0, 32'h0, 32'h0, rd, er, w, rc);
      ntests++; if ({er, rd} !== {1'b1, 32'hDEAD_0001}) begin nfail++; $display("FAIL to_resp: got %b %h want 1 dead0001", er, rd); end
      ntests++; if (rc - en_cyc != 16) begin nfail++; $display("FAIL to_cycles: got %0d want 16", rc - en_cyc); end
   endtask
`endif

   initial begin
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; use5 = 1'b0;
      mem_rdata = '0; mem_rdata5 = '0; mem_rvalid = '0;
      test_reset();
      test_wide_write();
      test_read_snapshot();
      test_errors();
      test_reset_mid_read();
      test_wpe1();
`ifdef APBMEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
